alpha_razor_stage: RTL and testbench

Forward-recursion (alpha) stage of the fully parallel turbo decoder. One instance per trellis step, placed directly upstream of the extrinsic stage. It takes the normalised state metrics of step k-1 and the branch LLRs of step k, and performs a max-log add-compare-select over the 8-state LTE constituent trellis. It then normalises the result to state 0, saturates it, and registers the seven non-zero metrics. A razor shadow latch on one bit per metric flags late-arriving results to the downstream extrinsic stage.

---
 rtl/fptd_pkg.sv | 65 ++++++
 rtl/alpha_razor_stage_bit_clip.sv | 23 ++
 rtl/alpha_razor_stage.sv | 130 +++++++++++++
 tb/tb_alpha_razor_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fptd_pkg.sv
// Shared trellis definitions for the fully parallel turbo decoder (LTE RSC,
// feedback 1+D^2+D^3, feedforward 1+D+D^3). State encoding is {d1,d2,d3},
// with d1 the most recent shift-register bit.
package fptd_pkg;

  localparam int unsigned NUM_STATES = 8;
  localparam int unsigned STATE_W    = 3;

  typedef logic [STATE_W-1:0] state_t;

  // Tables indexed [state][u]
  typedef logic [NUM_STATES-1:0][1:0][STATE_W-1:0] state_tab_t;
  typedef logic [NUM_STATES-1:0][1:0]              bit_tab_t;

  // Successor state for every (state, input) pair
  function automatic state_tab_t build_next_state();
    state_tab_t t;
    state_t     st;
    logic       fb;
    t = '0;
    for (int s = 0; s < int'(NUM_STATES); s++) begin
      for (int u = 0; u < 2; u++) begin
        st      = STATE_W'(s);
        fb      = 1'(u) ^ st[1] ^ st[0];
        t[s][u] = {fb, st[2], st[1]};
      end
    end
    return t;
  endfunction

  // Parity output for every (state, input) pair
  function automatic bit_tab_t build_parity();
    bit_tab_t t;
    state_t   st;
    logic     fb;
    t = '0;
    for (int s = 0; s < int'(NUM_STATES); s++) begin
      for (int u = 0; u < 2; u++) begin
        st      = STATE_W'(s);
        fb      = 1'(u) ^ st[1] ^ st[0];
        t[s][u] = fb ^ st[2] ^ st[0];
      end
    end
    return t;
  endfunction

  localparam state_tab_t NEXT_STATE = build_next_state();
  localparam bit_tab_t   PARITY     = build_parity();

  // Predecessor of state s' reached through input u; each state has exactly
  // one u=0 and one u=1 incoming branch in this trellis.
  function automatic state_tab_t build_prev_state();
    state_tab_t t;
    t = '0;
    for (int s = 0; s < int'(NUM_STATES); s++) begin
      for (int u = 0; u < 2; u++) begin
        t[NEXT_STATE[s][u]][u] = STATE_W'(s);
      end
    end
    return t;
  endfunction

  localparam state_tab_t PREV_STATE = build_prev_state();

endpackage

// File: rtl/alpha_razor_stage_bit_clip.sv
// BitClip: shared signed saturating clip from IN_W to OUT_W bits.
module BitClip #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 6
) (
  input  logic signed [IN_W-1:0]  value,
  output logic signed [OUT_W-1:0] clip_c
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Saturate to the signed OUT_W range
  always_comb begin
    clip_c = value[OUT_W-1:0];
    if (value > MAX_V) begin
      clip_c = MAX_V[OUT_W-1:0];
    end else if (value < MIN_V) begin
      clip_c = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/alpha_razor_stage.sv
// alpha_razor_stage: one forward-recursion step of the fully parallel turbo
// decoder. Max-log ACS over the 8-state trellis, normalised to state 0,
// saturated and registered. Optional razor shadow latch on one bit per metric
// is built only when FPTD_ALPHA_RAZOR_EN is defined; otherwise the error flag
// is tied low.
module alpha_razor_stage
  import fptd_pkg::*;
#(
  parameter int unsigned N        = 5,
  parameter int unsigned M        = 6,
  parameter int unsigned RazorBit = 1
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                Enable,
  input  logic                Error_previous,
  input  logic                Init,
  input  logic [7:1][M-1:0]   alpha_prev,
  input  logic [N-1:0]        ba1,
  input  logic [N-1:0]        bp,
  output logic [7:1][M-1:0]   alpha_DFF,
  output logic                Error_current_Alpha
);

  localparam int unsigned GW = N + 1;
  localparam int unsigned CW = M + 2;
  localparam int unsigned NW = M + 3;
  localparam logic [M-1:0] MIN_METRIC = {1'b1, {(M-1){1'b0}}};

  // Monitored bit position must lie inside the metric
  if (RazorBit < 1 || RazorBit > M) begin : g_bad_razor_bit
    $error("alpha_razor_stage: RazorBit out of range");
  end

  logic signed [GW-1:0] gamma    [4];
  logic signed [CW-1:0] prev_ext [NUM_STATES];
  logic signed [CW-1:0] alpha_new[NUM_STATES];
  logic [7:1][M-1:0]    alpha_next;

  // Branch metrics indexed by {u,p}
  always_comb begin
    gamma[0] = '0;
    gamma[1] = GW'(signed'(bp));
    gamma[2] = GW'(signed'(ba1));
    gamma[3] = GW'(signed'(ba1)) + GW'(signed'(bp));
  end

  // Previous metrics widened for candidate sums; state 0 is implicitly zero
  always_comb begin
    prev_ext[0] = '0;
    for (int s = 1; s < int'(NUM_STATES); s++) begin
      prev_ext[s] = CW'(signed'(alpha_prev[s]));
    end
  end

  // Add-compare-select per destination state; ties resolve to the u=0 branch
  for (genvar sp = 0; sp < int'(NUM_STATES); sp++) begin : g_acs
    localparam state_t P0 = PREV_STATE[sp][0];
    localparam state_t P1 = PREV_STATE[sp][1];
    localparam logic   Q0 = PARITY[P0][0];
    localparam logic   Q1 = PARITY[P1][1];

    logic signed [CW-1:0] cand0;
    logic signed [CW-1:0] cand1;

    assign cand0         = prev_ext[P0] + CW'(gamma[{1'b0, Q0}]);
    assign cand1         = prev_ext[P1] + CW'(gamma[{1'b1, Q1}]);
    assign alpha_new[sp] = (cand1 > cand0) ? cand1 : cand0;
  end

  // Normalise to state 0, saturate, and apply the initial-set override
  for (genvar sp = 1; sp < int'(NUM_STATES); sp++) begin : g_norm
    logic signed [NW-1:0] norm;
    logic signed [M-1:0]  clip_val;

    assign norm = NW'(alpha_new[sp]) - NW'(alpha_new[0]);

    BitClip #(
      .IN_W  (NW),
      .OUT_W (M)
    ) u_clip (
      .value  (norm),
      .clip_c (clip_val)
    );

    assign alpha_next[sp] = Init ? MIN_METRIC : clip_val;
  end

  // Metric register, captured only on a qualifying strobe
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      alpha_DFF <= '0;
    end else if (Enable && !Error_previous) begin
      alpha_DFF <= alpha_next;
    end
  end

`ifdef FPTD_ALPHA_RAZOR_EN
  localparam int unsigned RB = M - RazorBit;

  logic [7:1] alpha_LCH;
  logic [7:1] next_bits_c;
  logic [7:1] dff_bits_c;

  // Pick the monitored bit out of the next value and the stored value
  always_comb begin
    next_bits_c = '0;
    dff_bits_c  = '0;
    for (int s = 1; s < int'(NUM_STATES); s++) begin
      next_bits_c[s] = alpha_next[s][RB];
      dff_bits_c[s]  = alpha_DFF[s][RB];
    end
  end

  // Shadow latch: transparent during the high phase of an idle, error-free cycle
  always_latch begin
    if (!nReset) begin
      alpha_LCH <= '0;
    end else if (!Enable && !Error_previous && Clock) begin
      alpha_LCH <= next_bits_c;
    end
  end

  // Any disagreement between shadow and main copy marks a late result
  assign Error_current_Alpha = |(alpha_LCH ^ dff_bits_c);
`else
  assign Error_current_Alpha = 1'b0;
`endif

endmodule

// File: tb/tb_alpha_razor_stage.sv
// Self-checking bench for alpha_razor_stage (N=5, M=6, RazorBit=1).
// Razor expectations follow FPTD_ALPHA_RAZOR_EN.
module tb_alpha_razor_stage;

  typedef logic [7:1][5:0] metrics_t;

  typedef struct {
    string           name;
    logic            init;
    metrics_t        prev;
    logic [4:0]      a;
    logic [4:0]      b;
    metrics_t        exp;
  } vec_t;

`ifdef FPTD_ALPHA_RAZOR_EN
  localparam bit RAZOR_ON = 1'b1;
`else
  localparam bit RAZOR_ON = 1'b0;
`endif

  logic       Clock;
  logic       nReset;
  logic       Enable;
  logic       Error_previous;
  logic       Init;
  metrics_t   alpha_prev;
  logic [4:0] ba1;
  logic [4:0] bp;
  metrics_t   alpha_DFF;
  logic       Error_current_Alpha;

  int checks = 0;
  int errors = 0;

  alpha_razor_stage #(
    .N        (5),
    .M        (6),
    .RazorBit (1)
  ) dut (
    .Clock               (Clock),
    .nReset              (nReset),
    .Enable              (Enable),
    .Error_previous      (Error_previous),
    .Init                (Init),
    .alpha_prev          (alpha_prev),
    .ba1                 (ba1),
    .bp                  (bp),
    .alpha_DFF           (alpha_DFF),
    .Error_current_Alpha (Error_current_Alpha)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic metrics_t pack7(input int v1, v2, v3, v4, v5, v6, v7);
    metrics_t r;
    r[1] = 6'(v1); r[2] = 6'(v2); r[3] = 6'(v3); r[4] = 6'(v4);
    r[5] = 6'(v5); r[6] = 6'(v6); r[7] = 6'(v7);
    return r;
  endfunction

  // Reference model built straight from the shift-register description
  function automatic metrics_t model(input logic init_v, input metrics_t pv,
                                     input logic [4:0] a, input logic [4:0] b);
    int pm[8];
    int an[8];
    int d1, d2, d3, fb, ns, p, c, nv;
    metrics_t r;
    pm[0] = 0;
    for (int s = 1; s < 8; s++) pm[s] = int'($signed(pv[s]));
    for (int s = 0; s < 8; s++) an[s] = -100000;
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        d1 = (s >> 2) & 1; d2 = (s >> 1) & 1; d3 = s & 1;
        fb = u ^ d2 ^ d3;
        ns = fb * 4 + d1 * 2 + d2;
        p  = fb ^ d1 ^ d3;
        c  = pm[s] + u * int'($signed(a)) + p * int'($signed(b));
        if (c > an[ns]) an[ns] = c;
      end
    end
    for (int s = 1; s < 8; s++) begin
      nv = an[s] - an[0];
      if (nv > 31)  nv = 31;
      if (nv < -32) nv = -32;
      r[s] = init_v ? 6'h20 : 6'(nv);
    end
    return r;
  endfunction

  task automatic check_m(input string name, input metrics_t act, input metrics_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: alpha_DFF got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One qualifying capture, then idle high phase where the shadow re-tracks
  task automatic run_vec(input string name, input logic init_v, input metrics_t prev_v,
                         input logic [4:0] a_v, input logic [4:0] b_v, input metrics_t exp_v);
    @(negedge Clock);
    Init = init_v; alpha_prev = prev_v; ba1 = a_v; bp = b_v;
    Enable = 1'b1; Error_previous = 1'b0;
    @(posedge Clock); #1;
    check_m(name, alpha_DFF, exp_v);
    Enable = 1'b0;
    #1;
    check_b({name, "_err"}, Error_current_Alpha, 1'b0);
  endtask

  vec_t     vecs[6];
  metrics_t held;
  metrics_t rp;
  logic [4:0] ra, rb;

  initial begin
    vecs[0] = '{"init",      1'b1, pack7(5, -3, 12, 0, -20, 31, 7), 5'd7, 5'h1E,
                pack7(-32, -32, -32, -32, -32, -32, -32)};
    vecs[1] = '{"recursion", 1'b0, pack7(-32, -32, -32, -32, -32, -32, -32), 5'd0, 5'd0,
                pack7(-32, -32, -32, 0, -32, -32, -32)};
    vecs[2] = '{"uniform_p3", 1'b0, pack7(0, 0, 0, 0, 0, 0, 0), 5'd3, 5'd0,
                pack7(0, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{"uniform_m4", 1'b0, pack7(0, 0, 0, 0, 0, 0, 0), 5'h1C, 5'd0,
                pack7(0, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{"sat_low",   1'b0, pack7(31, 0, 0, 0, 0, 0, 0), 5'd15, 5'd15,
                pack7(-32, -32, -31, -30, -32, -32, -31)};
    vecs[5] = '{"sat_high",  1'b0, pack7(-32, 31, 31, 31, 31, 31, 31), 5'd15, 5'd15,
                pack7(31, 31, 31, 30, 31, 31, 31)};

    nReset = 1'b0; Enable = 1'b0; Error_previous = 1'b0; Init = 1'b0;
    alpha_prev = '0; ba1 = '0; bp = '0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      alpha_prev = metrics_t'({$urandom, $urandom});
      ba1 = 5'($urandom); bp = 5'($urandom);
      Init = 1'($urandom); Enable = 1'(i & 1);
      @(posedge Clock); #1;
      check_m("reset_hold", alpha_DFF, '0);
      check_b("reset_hold_err", Error_current_Alpha, 1'b0);
    end
    @(negedge Clock);
    Enable = 1'b0; Init = 1'b0;
    nReset = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i].name, vecs[i].init, vecs[i].prev, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Random vectors against the reference model
    for (int i = 0; i < 10; i++) begin
      for (int s = 1; s < 8; s++) rp[s] = 6'($urandom);
      ra = 5'($urandom); rb = 5'($urandom);
      run_vec("random", 1'b0, rp, ra, rb, model(1'b0, rp, ra, rb));
    end

    // Upstream error blocks capture even with Enable and Init asserted
    held = alpha_DFF;
    @(negedge Clock);
    Init = 1'b1; Enable = 1'b1; Error_previous = 1'b1;
    @(posedge Clock); #1;
    check_m("errprev_hold", alpha_DFF, held);
    check_b("errprev_err", Error_current_Alpha, 1'b0);

    // Known zero state, then change the next value while idle in the high phase
    run_vec("razor_base", 1'b0, pack7(0, 0, 0, 0, 0, 0, 0), 5'd3, 5'd0,
            pack7(0, 0, 0, 0, 0, 0, 0));
    @(negedge Clock);
    Init = 1'b1; Enable = 1'b0; Error_previous = 1'b0;
    @(posedge Clock); #1;
    check_m("razor_idle_hold", alpha_DFF, '0);
    check_b("razor_flag", Error_current_Alpha, RAZOR_ON);
    @(negedge Clock); #1;
    check_b("razor_flag_low_phase", Error_current_Alpha, RAZOR_ON);
    Enable = 1'b1;
    @(posedge Clock); #1;
    check_m("razor_capture", alpha_DFF, pack7(-32, -32, -32, -32, -32, -32, -32));
    check_b("razor_cleared", Error_current_Alpha, 1'b0);
    Enable = 1'b0;

    // Asynchronous reset in the middle of the low phase
    @(negedge Clock); #3;
    nReset = 1'b0;
    #1;
    check_m("async_reset", alpha_DFF, '0);
    check_b("async_reset_err", Error_current_Alpha, 1'b0);
    @(negedge Clock);
    nReset = 1'b1; Init = 1'b0;
    @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
